// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage with a 2-entry valid/ready output FIFO.
// Define SR_BYPASS_EN to add the per-entry in_bypass port (store the state unshifted).
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
`ifdef SR_BYPASS_EN
    input  logic              in_bypass,
`endif
    input  logic [32*NB-1:0]  in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    localparam int W  = 32 * NB;
    localparam int S1 = 1;
    localparam int S2 = (NB == 8) ? 3 : 2;
    localparam int S3 = (NB >= 7) ? 4 : 3;

    if (NB < 4 || NB > 8) begin : g_nb_check
        $error("shift_rows_pipe: NB must be in 4..8");
    end

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready and out_valid come only from registered occupancy, never from the other side.

    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] res;
        int           s;
        int           src_f;
        int           src_i;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s = (r == 0) ? 0 : (r == 1) ? S1 : (r == 2) ? S2 : S3;
            for (int c = 0; c < NB; c++) begin
                src_f = (c + s) % NB;
                src_i = (c - s + NB) % NB;
                res[W-1-8*(r+4*c) -: 8] = inv ? d[W-1-8*(r+4*src_i) -: 8]
                                              : d[W-1-8*(r+4*src_f) -: 8];
            end
        end
        return res;
    endfunction

    logic [W-1:0]     xform_data;
    logic [W-1:0]     data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

`ifdef SR_BYPASS_EN
    assign xform_data = in_bypass ? in_data : shift_rows(in_data, in_inv);
`else
    assign xform_data = shift_rows(in_data, in_inv);
`endif

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign occupancy = count_q;
    assign out_data  = data_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];

    // flush wins over any push or pop in the same cycle
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= xform_data;
            tag_q[wr_ptr_q]  <= in_tag;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB=4 instance with a queue scoreboard, NB=8 instance
// with directed byte checks. Exercises SR_BYPASS_EN paths when that macro is defined.
module tb_shift_rows_pipe;

  localparam int TAG_W = 4;
  localparam int W4    = 128;
  localparam int W8    = 256;

  localparam logic [W4-1:0] V0      = 128'h5a2c6d7e0b15b39fa8f5c6d5a6c9d4a1;
  localparam logic [W4-1:0] V0_FWD  = 128'h5a15c6a10bf5d47ea8c96d9fa62cb3d5;
  localparam logic [W4-1:0] V0_INV  = 128'h5ac9c69f0b2cd4d5a8156da1a6f5b37e;
  localparam logic [W8-1:0] NB8_FWD =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // NB=4 instance
  logic             flush4, in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [W4-1:0]    in_data4, out_data4;
  logic [TAG_W-1:0] in_tag4, out_tag4;
  logic [1:0]       occupancy4;
`ifdef SR_BYPASS_EN
  logic             in_bypass4;
  logic             in_bypass8;
`endif

  // NB=8 instance
  logic             flush8, in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [W8-1:0]    in_data8, out_data8;
  logic [TAG_W-1:0] in_tag8, out_tag8;
  logic [1:0]       occupancy8;

  shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4),
`ifdef SR_BYPASS_EN
    .in_bypass(in_bypass4),
`endif
    .in_data(in_data4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_tag(out_tag4), .occupancy(occupancy4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
`ifdef SR_BYPASS_EN
    .in_bypass(in_bypass8),
`endif
    .in_data(in_data8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_tag(out_tag8), .occupancy(occupancy8)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: state as a 4 x NB byte matrix, rows rotated by the Rijndael offsets.
  function automatic logic [255:0] model_sr(input logic [255:0] din, input int nb, input bit inv);
    logic [7:0]   st  [4][8];
    logic [7:0]   res [4][8];
    int           sh  [4];
    logic [255:0] dout;
    sh = '{0, 1, 2, 3};
    if (nb == 7) sh = '{0, 1, 2, 4};
    if (nb == 8) sh = '{0, 1, 3, 4};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = din[32*nb-1-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        res[r][c] = inv ? st[r][(c - sh[r] + nb) % nb] : st[r][(c + sh[r]) % nb];
    dout = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        dout[32*nb-1-8*(r+4*c) -: 8] = res[r][c];
    return dout;
  endfunction

  // scoreboard for the NB=4 instance: {data, tag}
  logic [W4+TAG_W-1:0] exp_q[$];
  logic [TAG_W-1:0]    popped_q[$];

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      int           sz;
      bit           bypass;
      logic [255:0] m;
      logic [W4-1:0] e;
      sz = exp_q.size();
      chk("occupancy", 256'(occupancy4), 256'(sz));
      chk("out_valid", 256'(out_valid4), 256'(sz != 0));
      chk("in_ready", 256'(in_ready4), 256'(sz < 2));
      if (sz != 0) begin
        chk("sb_out_data", 256'(out_data4), 256'(exp_q[0][W4+TAG_W-1:TAG_W]));
        chk("sb_out_tag", 256'(out_tag4), 256'(exp_q[0][TAG_W-1:0]));
      end
      if (flush4) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && out_ready4) begin
          popped_q.push_back(out_tag4);
          void'(exp_q.pop_front());
        end
        if (in_valid4 && sz < 2) begin
          bypass = 1'b0;
`ifdef SR_BYPASS_EN
          bypass = in_bypass4;
`endif
          m = model_sr(256'(in_data4), 4, in_inv4);
          e = bypass ? in_data4 : m[W4-1:0];
          exp_q.push_back({e, in_tag4});
        end
      end
    end
  end

  // driver: present a state and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic push4(input logic [W4-1:0] d, input logic inv, input logic [TAG_W-1:0] tag);
    bit acc;
    int budget;
    in_valid4 = 1'b1;
    in_data4  = d;
    in_inv4   = inv;
    in_tag4   = tag;
    budget    = 0;
    do begin
      acc = in_ready4;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL push_timeout: tag %0d not accepted within %0d cycles", tag, budget);
    end
  endtask

  task automatic idle4();
    in_valid4 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W4-1:0]  d;
    logic [W8-1:0]  d8;
    logic [W8-1:0]  m8;
    int             c0;
    rst_n = 1'b0;
    flush4 = 1'b0; in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; in_tag4 = '0; out_ready4 = 1'b1;
    flush8 = 1'b0; in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; in_tag8 = '0; out_ready8 = 1'b1;
`ifdef SR_BYPASS_EN
    in_bypass4 = 1'b0;
    in_bypass8 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cycles(1);

    // reset state
    chk("rst_occupancy", 256'(occupancy4), 256'(0));
    chk("rst_out_valid", 256'(out_valid4), 256'(0));
    chk("rst_in_ready", 256'(in_ready4), 256'(1));
    chk("rst_out_data", 256'(out_data4), 256'(0));
    chk("rst_out_tag", 256'(out_tag4), 256'(0));
    chk("rst8_occupancy", 256'(occupancy8), 256'(0));

    // forward, inverse, and inverse fed back through forward
    push4(V0, 1'b0, 4'd3);
    idle4();
    chk("fwd_out_valid", 256'(out_valid4), 256'(1));
    chk("fwd_out_data", 256'(out_data4), 256'(V0_FWD));
    chk("fwd_out_tag", 256'(out_tag4), 256'(3));
    cycles(1);
    push4(V0, 1'b1, 4'd5);
    idle4();
    chk("inv_out_data", 256'(out_data4), 256'(V0_INV));
    cycles(1);
    push4(V0_INV, 1'b0, 4'd6);
    idle4();
    chk("roundtrip_out_data", 256'(out_data4), 256'(V0));
    cycles(1);

    // back-pressure: two accepted, third held at the input
    out_ready4 = 1'b0;
    push4(128'h00112233445566778899aabbccddeeff, 1'b0, 4'd1);
    push4(128'hfedcba98765432100123456789abcdef, 1'b1, 4'd2);
    in_valid4 = 1'b1;
    in_data4  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    in_inv4   = 1'b0;
    in_tag4   = 4'd3;
    cycles(3);
    chk("bp_occupancy", 256'(occupancy4), 256'(2));
    chk("bp_in_ready", 256'(in_ready4), 256'(0));
    chk("bp_head_tag", 256'(out_tag4), 256'(1));
    m8 = model_sr(256'(128'h00112233445566778899aabbccddeeff), 4, 1'b0);
    chk("bp_head_data", 256'(out_data4), 256'(m8[W4-1:0]));
    popped_q.delete();
    out_ready4 = 1'b1;
    push4(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0, 4'd3);
    idle4();
    cycles(3);
    chk("bp_pop_count", 256'(popped_q.size()), 256'(3));
    if (popped_q.size() == 3) begin
      chk("bp_order0", 256'(popped_q[0]), 256'(1));
      chk("bp_order1", 256'(popped_q[1]), 256'(2));
      chk("bp_order2", 256'(popped_q[2]), 256'(3));
    end

    // streaming, alternating direction, one state per cycle
    popped_q.delete();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      d = {32'(i) * 32'h9e3779b9, 32'(i) * 32'h7f4a7c15 + 32'h1234,
           ~32'(i) * 32'h85ebca6b, 32'(i + 7) * 32'hc2b2ae35};
      push4(d, i[0], i[3:0]);
    end
    idle4();
    chk("stream_cycles", 256'(cyc - c0), 256'(16));
    cycles(3);
    chk("stream_pop_count", 256'(popped_q.size()), 256'(16));

    // flush while full, with a concurrent push
    out_ready4 = 1'b0;
    push4(128'h11111111222222223333333344444444, 1'b0, 4'd7);
    push4(128'h55555555666666667777777788888888, 1'b1, 4'd8);
    in_data4 = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
    in_tag4  = 4'd9;
    flush4   = 1'b1;
    cycles(1);
    flush4 = 1'b0;
    idle4();
    chk("flush_full_occupancy", 256'(occupancy4), 256'(0));
    chk("flush_full_out_valid", 256'(out_valid4), 256'(0));

    // flush with one entry and an acceptable push: the push is dropped
    push4(128'h11111111222222223333333344444444, 1'b0, 4'd7);
    in_data4 = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
    in_tag4  = 4'd9;
    flush4   = 1'b1;
    cycles(1);
    flush4 = 1'b0;
    idle4();
    chk("flush_one_occupancy", 256'(occupancy4), 256'(0));
    cycles(2);
    chk("flush_one_out_valid", 256'(out_valid4), 256'(0));
    out_ready4 = 1'b1;
    cycles(1);

    // asynchronous reset mid-stream
    out_ready4 = 1'b0;
    push4(128'hdeadbeefcafef00d0123456789abcdef, 1'b0, 4'd4);
    push4(128'h0badc0de13572468fedcba9876543210, 1'b1, 4'd5);
    idle4();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_occupancy", 256'(occupancy4), 256'(0));
    chk("arst_out_valid", 256'(out_valid4), 256'(0));
    chk("arst_out_data", 256'(out_data4), 256'(0));
    chk("arst_out_tag", 256'(out_tag4), 256'(0));
    chk("arst_in_ready", 256'(in_ready4), 256'(1));
    @(posedge clk);
    #4 rst_n = 1'b1;
    cycles(2);
    chk("post_rst_out_valid", 256'(out_valid4), 256'(0));
    chk("post_rst_in_ready", 256'(in_ready4), 256'(1));
    out_ready4 = 1'b1;
    push4(V0, 1'b0, 4'd2);
    idle4();
    chk("post_rst_out_data", 256'(out_data4), 256'(V0_FWD));
    cycles(1);

`ifdef SR_BYPASS_EN
    in_bypass4 = 1'b1;
    push4(V0, 1'b1, 4'd4);
    idle4();
    in_bypass4 = 1'b0;
    chk("bypass_out_data", 256'(out_data4), 256'(V0));
    cycles(1);
`endif

    // NB=8 forward, byte k = k
    for (int k = 0; k < 32; k++) d8[W8-1-8*k -: 8] = 8'(k);
    in_data8  = d8;
    in_tag8   = 4'ha;
    in_valid8 = 1'b1;
    cycles(1);
    in_valid8 = 1'b0;
    chk("nb8_out_valid", 256'(out_valid8), 256'(1));
    chk("nb8_out_data", out_data8, NB8_FWD);
    chk("nb8_out_tag", 256'(out_tag8), 256'(4'ha));
    m8 = model_sr(d8, 8, 1'b0);
    for (int k = 0; k < 32; k++)
      chk($sformatf("nb8_byte%0d", k), 256'(out_data8[W8-1-8*k -: 8]), 256'(m8[W8-1-8*k -: 8]));
    cycles(1);

`ifdef SR_BYPASS_EN
    in_bypass8 = 1'b1;
    in_inv8    = 1'b1;
    in_valid8  = 1'b1;
    cycles(1);
    in_valid8  = 1'b0;
    in_bypass8 = 1'b0;
    in_inv8    = 1'b0;
    chk("nb8_bypass_out_data", out_data8, d8);
    cycles(1);
`endif

    cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: run did not complete by time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Registered, flow-controlled ShiftRows / InvShiftRows unit, parametrised in state width (Rijndael Nb = 4..8 columns).
- Mode is selected per transaction, so one instance serves both the encrypt and decrypt round datapaths.
- Sits between the SubBytes/InvSubBytes stage and MixColumns/AddRoundKey in the pipelined round core.
- Uses valid/ready handshakes and a 2-entry output buffer, so downstream back-pressure never drops a state.

Parameters:
- NB, 4, state columns (legal 4..8); state width W = 32*NB bits.
- TAG_W, 4, width of the sideband tag carried alongside each state (legal >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all buffered states.
- in_valid  input  1  input state valid.
- in_ready  output  1  unit can accept a state this cycle.
- in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows.
- in_data  input  W  input state.
- in_tag  input  TAG_W  sideband tag, passed through unmodified.
- out_valid  output  1  output state valid.
- out_ready  input  1  downstream accepts.
- out_data  output  W  transformed state.
- out_tag  output  TAG_W  tag of out_data.
- occupancy  output  2  buffered entries, 0..2.

Behaviour:
- State layout is column-major. Byte k = r + 4c (r = row 0..3, c = column 0..NB-1) occupies bits [W-1-8k -: 8]. Byte 0 is the MSB byte.
- Row offsets s(r):
  - s(0) = 0 for all NB.
  - NB 4..6: s(1)=1, s(2)=2, s(3)=3.
  - NB 7: 1, 2, 4.
  - NB 8: 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r)) mod NB].
- The transform is combinational on in_data. The result, tag and mode are written into a 2-entry FIFO.
- out_data and out_tag always come from FIFO head registers, never combinationally from the input.
- Accept occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (occupancy < 2). It depends only on registered state; there is no ready-through path.
- out_valid = (occupancy != 0).
- Latency: accept at edge N gives out_valid high after edge N (visible in cycle N+1).
- Full throughput: one state per cycle, provided out_ready stays high.
- Simultaneous push and pop:
  - occupancy 1: occupancy stays 1, order is preserved.
  - occupancy 2: push is impossible because in_ready = 0; the pop alone leaves occupancy 1.
  - occupancy 0: no pop is possible; occupancy becomes 1.
- While out_valid is high and out_ready is low, out_data and out_tag hold stable.
- Order is strict FIFO. Mode is latched per entry, so back-to-back entries may differ in direction.
- flush: occupancy goes to 0 on the next edge. A push in the same cycle is dropped; flush has priority.
- Async reset (rst_n low):
  - occupancy = 0, out_valid = 0, in_ready = 1.
  - out_data = 0, out_tag = 0; head/tail pointers = 0.
  - Reset mid-transfer loses all buffered states. No partial output is allowed after release.
- Undefined NB (outside 4..8) raises an elaboration-time error.

Optional Feature:
- Macro SR_BYPASS_EN.
- When defined:
  - Adds port in_bypass (input, 1 bit), latched per entry like in_inv.
  - in_bypass = 1 stores in_data unshifted, regardless of in_inv. This is used by the final-round debug path and for test loopback.
  - Handshake, latency and ordering are unchanged.
- When undefined:
  - The port is absent and every entry is transformed per in_inv.
  - No bypass logic is synthesised.

Test Plan:
- NB=4, in_inv=0, in_data=128'h5a2c6d7e0b15b39fa8f5c6d5a6c9d4a1, tag 3, out_ready=1 -> next cycle out_valid=1, out_data=128'h5a15c6a10bf5d47ea8c96d9fa62cb3d5, out_tag=3.
- NB=4, in_inv=1, same in_data -> out_data=128'h5ac9c69f0b2cd4d5a8156da1a6f5b37e. Feeding that back with in_inv=0 returns the original state.
- Back-pressure with out_ready=0:
  - Push 3 states with tags 1, 2, 3 -> tags 1 and 2 accepted, occupancy=2, in_ready=0, and tag 3 is held at the input.
  - Raise out_ready -> outputs emerge in order 1, 2, 3 with no loss or duplication. out_data is stable while stalled.
- Streaming with alternating in_inv for 16 consecutive states, out_ready=1 -> one output per cycle, each matching a reference model for its own mode.
- Flush and reset:
  - occupancy=2, assert flush together with in_valid -> next cycle occupancy=0, out_valid=0, and the incoming state is dropped.
  - Assert rst_n low asynchronously mid-stream -> outputs clear immediately, and in_ready=1 after release.
- NB=8, forward mode, with in_data byte k = k -> row shifts are 0/1/3/4, checked byte-by-byte. With SR_BYPASS_EN and in_bypass=1, out_data == in_data.
